// File: rtl/fp_div_dispatch.sv
// Requester-side dispatcher for the shared sequential FP divider: arbitrates core requests,
// gates issue on response credit, and queues returned results. Define FP_DIV_DISPATCH_RR_EN for round-robin arbitration.
module fp_div_dispatch #(
  parameter int NUM_PORTS  = 4,
  parameter int FP_WIDTH   = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int RND_WIDTH  = 3,
  parameter int STAT_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int PW  = $clog2(NUM_PORTS),
  localparam int DTW = TAG_WIDTH + PW
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_PORTS-1:0]            req_i,
  input  logic [NUM_PORTS*FP_WIDTH-1:0]   opa_i,
  input  logic [NUM_PORTS*FP_WIDTH-1:0]   opb_i,
  input  logic [NUM_PORTS*RND_WIDTH-1:0]  rnd_i,
  input  logic [NUM_PORTS*TAG_WIDTH-1:0]  tag_i,
  output logic [NUM_PORTS-1:0]            gnt_o,
  output logic                            div_en_o,
  output logic [FP_WIDTH-1:0]             div_opa_o,
  output logic [FP_WIDTH-1:0]             div_opb_o,
  output logic [RND_WIDTH-1:0]            div_rnd_o,
  output logic [DTW-1:0]                  div_tag_o,
  input  logic                            div_ready_i,
  input  logic                            div_valid_i,
  input  logic [FP_WIDTH-1:0]             div_res_i,
  input  logic [STAT_WIDTH-1:0]           div_status_i,
  input  logic [DTW-1:0]                  div_tag_i,
  output logic                            resp_valid_o,
  input  logic                            resp_ready_i,
  output logic [FP_WIDTH-1:0]             resp_res_o,
  output logic [STAT_WIDTH-1:0]           resp_status_o,
  output logic [TAG_WIDTH-1:0]            resp_tag_o,
  output logic [PW-1:0]                   resp_port_o,
  output logic                            err_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = FP_WIDTH + STAT_WIDTH + TAG_WIDTH + PW;

  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          err_q, err_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] push_entry, head;

  logic [CW:0]   credit_sum;
  logic          credit_ok, issue, push, pop;
  logic [PW-1:0] win;

  // Credit counts both outstanding divider ops and queued results, so every return has a slot.
  assign credit_sum = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
  assign credit_ok  = credit_sum < (CW+1)'(FIFO_DEPTH);
  assign issue      = (|req_i) & div_ready_i & credit_ok & ~rst_i;

`ifdef FP_DIV_DISPATCH_RR_EN
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    logic [PW-1:0] idx;
    win = '0;
    idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr_q) + k) % NUM_PORTS);
      if (req_i[idx]) win = idx;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) rr_ptr_d = (win == PW'(NUM_PORTS - 1)) ? '0 : win + PW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    logic [PW-1:0] idx;
    win = '0;
    idx = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      idx = PW'(p);
      if (req_i[idx]) win = idx;
    end
  end
`endif

  assign gnt_o     = issue ? (NUM_PORTS'(1) << win) : '0;
  assign div_en_o  = issue;
  assign div_opa_o = opa_i[win*FP_WIDTH +: FP_WIDTH];
  assign div_opb_o = opb_i[win*FP_WIDTH +: FP_WIDTH];
  assign div_rnd_o = rnd_i[win*RND_WIDTH +: RND_WIDTH];
  assign div_tag_o = {win, tag_i[win*TAG_WIDTH +: TAG_WIDTH]};

  // A return with nothing outstanding is dropped and flagged rather than queued.
  assign push         = div_valid_i & (inflight_q != '0);
  assign resp_valid_o = fifo_cnt_q != '0;
  assign pop          = resp_valid_o & resp_ready_i;
  assign push_entry   = {div_res_i, div_status_i, div_tag_i[TAG_WIDTH-1:0], div_tag_i[DTW-1:TAG_WIDTH]};

  always_comb begin
    inflight_d = inflight_q;
    fifo_cnt_d = fifo_cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    err_d      = err_q | (div_valid_i & (inflight_q == '0));
    if (issue && !push) inflight_d = inflight_q + CW'(1);
    if (!issue && push) inflight_d = inflight_q - CW'(1);
    if (push && !pop)   fifo_cnt_d = fifo_cnt_q + CW'(1);
    if (!push && pop)   fifo_cnt_d = fifo_cnt_q - CW'(1);
    if (push)           wptr_d     = wptr_q + AW'(1);
    if (pop)            rptr_d     = rptr_q + AW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      err_q      <= err_d;
    end
  end

  // Payload storage carries no reset; occupancy alone qualifies it.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= push_entry;
  end

  assign head          = mem_q[rptr_q];
  assign resp_res_o    = head[EW-1 -: FP_WIDTH];
  assign resp_status_o = head[PW+TAG_WIDTH +: STAT_WIDTH];
  assign resp_tag_o    = head[PW +: TAG_WIDTH];
  assign resp_port_o   = head[PW-1:0];
  assign err_o         = err_q;

endmodule

// File: tb/tb_fp_div_dispatch.sv
// Randomized bench for fp_div_dispatch against a queue-based behavioural model and a simple divider stand-in.
module tb_fp_div_dispatch;
  localparam int NP = 4, FW = 32, TW = 4, RW = 3, SW = 8, FD = 4, PW = 2, DTW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NP-1:0]     req;
  logic [NP*FW-1:0]  opa, opb;
  logic [NP*RW-1:0]  rnd;
  logic [NP*TW-1:0]  tag;
  logic [NP-1:0]     gnt_o;
  logic              div_en_o;
  logic [FW-1:0]     div_opa_o, div_opb_o;
  logic [RW-1:0]     div_rnd_o;
  logic [DTW-1:0]    div_tag_o;
  logic              div_ready, div_valid;
  logic [FW-1:0]     div_res;
  logic [SW-1:0]     div_status;
  logic [DTW-1:0]    div_tag;
  logic              resp_valid_o, resp_ready;
  logic [FW-1:0]     resp_res_o;
  logic [SW-1:0]     resp_status_o;
  logic [TW-1:0]     resp_tag_o;
  logic [PW-1:0]     resp_port_o;
  logic              err_o;

  fp_div_dispatch #(
    .NUM_PORTS(NP), .FP_WIDTH(FW), .TAG_WIDTH(TW), .RND_WIDTH(RW),
    .STAT_WIDTH(SW), .FIFO_DEPTH(FD)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .opa_i(opa), .opb_i(opb),
    .rnd_i(rnd), .tag_i(tag), .gnt_o(gnt_o), .div_en_o(div_en_o),
    .div_opa_o(div_opa_o), .div_opb_o(div_opb_o), .div_rnd_o(div_rnd_o),
    .div_tag_o(div_tag_o), .div_ready_i(div_ready), .div_valid_i(div_valid),
    .div_res_i(div_res), .div_status_i(div_status), .div_tag_i(div_tag),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready),
    .resp_res_o(resp_res_o), .resp_status_o(resp_status_o),
    .resp_tag_o(resp_tag_o), .resp_port_o(resp_port_o), .err_o(err_o)
  );

  typedef struct {
    logic [FW-1:0] res;
    logic [SW-1:0] st;
    logic [TW-1:0] tag;
    logic [PW-1:0] port;
  } resp_t;

  typedef struct {
    int             due;
    logic [FW-1:0]  res;
    logic [SW-1:0]  st;
    logic [DTW-1:0] tag;
  } dop_t;

  resp_t mq[$];
  dop_t  dq[$];
  int    m_infl, m_ptr, cyc, lat, n_issue;
  bit    m_err, spur, pr_issue;
  int    pr_win;
  int    errors, checks;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Divider stand-in: x/1.0 returns x exactly, anything else returns a scrambled value.
  function automatic logic [FW-1:0] stub(input logic [FW-1:0] a, input logic [FW-1:0] b);
    return (b == 32'h3F80_0000) ? a : (a ^ b);
  endfunction

  function automatic int pick(input logic [NP-1:0] r, input int ptr);
    for (int k = 0; k < NP; k++)
      if (r[PW'((ptr + k) % NP)]) return (ptr + k) % NP;
    return 0;
  endfunction

  task automatic drive_settle();
    if (rst) begin
      div_valid = 1'b0;
    end else if (spur) begin
      div_valid  = 1'b1;
      div_res    = $urandom;
      div_status = SW'($urandom);
      div_tag    = DTW'($urandom);
    end else if (dq.size() > 0 && dq[0].due <= cyc) begin
      div_valid  = 1'b1;
      div_res    = dq[0].res;
      div_status = dq[0].st;
      div_tag    = dq[0].tag;
    end else begin
      div_valid  = 1'b0;
    end
    #1;
    pr_issue = (|req) && div_ready && (m_infl + mq.size() < FD) && !rst;
    pr_win   = pick(req, m_ptr);
    chk("gnt", 64'(gnt_o), pr_issue ? 64'(1) << pr_win : 64'(0));
    chk("div_en", 64'(div_en_o), 64'(pr_issue));
    if (pr_issue) begin
      chk("div_opa", 64'(div_opa_o), 64'(opa[pr_win*FW +: FW]));
      chk("div_opb", 64'(div_opb_o), 64'(opb[pr_win*FW +: FW]));
      chk("div_rnd", 64'(div_rnd_o), 64'(rnd[pr_win*RW +: RW]));
      chk("div_tag", 64'(div_tag_o), 64'({PW'(pr_win), tag[pr_win*TW +: TW]}));
    end
    chk("resp_valid", 64'(resp_valid_o), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("resp_res", 64'(resp_res_o), 64'(mq[0].res));
      chk("resp_status", 64'(resp_status_o), 64'(mq[0].st));
      chk("resp_tag", 64'(resp_tag_o), 64'(mq[0].tag));
      chk("resp_port", 64'(resp_port_o), 64'(mq[0].port));
    end
    chk("err", 64'(err_o), 64'(m_err));
    if (div_en_o) n_issue++;
  endtask

  task automatic advance();
    resp_t e;
    dop_t  d;
    int    w;
    if (rst) begin
      mq.delete();
      dq.delete();
      m_infl = 0;
      m_ptr  = 0;
      m_err  = 1'b0;
    end else begin
      if (div_valid && m_infl == 0) m_err = 1'b1;
      if (div_valid && !spur) dq.delete(0);
      if (mq.size() != 0 && resp_ready) mq.delete(0);
      if (div_valid && m_infl > 0) begin
        e.res  = div_res;
        e.st   = div_status;
        e.tag  = div_tag[TW-1:0];
        e.port = div_tag[DTW-1:TW];
        mq.push_back(e);
        m_infl--;
      end
      if (pr_issue) begin
        w     = pr_win;
        d.due = cyc + lat;
        d.res = stub(opa[w*FW +: FW], opb[w*FW +: FW]);
        d.st  = SW'($urandom);
        d.tag = {PW'(w), tag[w*TW +: TW]};
        dq.push_back(d);
        m_infl++;
`ifdef FP_DIV_DISPATCH_RR_EN
        m_ptr = (w + 1) % NP;
`endif
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick();
    drive_settle();
    advance();
  endtask

  task automatic rand_operands();
    opa = {$urandom, $urandom, $urandom, $urandom};
    opb = {$urandom, $urandom, $urandom, $urandom};
    rnd = (NP*RW)'($urandom);
    tag = (NP*TW)'($urandom);
  endtask

  initial begin
    int vcyc, rcyc, icyc;
    bit seen;
    errors = 0; checks = 0; cyc = 0; lat = 4; n_issue = 0;
    m_infl = 0; m_ptr = 0; m_err = 1'b0; spur = 1'b0;
    rst = 1'b1; req = '0; div_ready = 1'b1; resp_ready = 1'b0;
    div_valid = 1'b0; div_res = '0; div_status = '0; div_tag = '0;
    rand_operands();
    @(posedge clk);
    #1;
    tick();
    chk("reset_inflight", 64'(dut.inflight_q), 64'(0));
    rst = 1'b0;

    // Single op: port 2, 3.0 / 1.0, tag 5
    req = 4'b0100;
    opa[2*FW +: FW] = 32'h4040_0000;
    opb[2*FW +: FW] = 32'h3F80_0000;
    tag[2*TW +: TW] = 4'd5;
    lat = 4;
    drive_settle();
    chk("single_gnt", 64'(gnt_o), 64'(4'b0100));
    icyc = cyc;
    advance();
    req = '0;
    seen = 1'b0; vcyc = -1; rcyc = -1;
    for (int i = 0; i < 12 && !seen; i++) begin
      drive_settle();
      if (div_valid) vcyc = cyc;
      if (resp_valid_o) begin
        seen = 1'b1;
        rcyc = cyc;
        chk("single_res", 64'(resp_res_o), 64'(32'h4040_0000));
        chk("single_tag", 64'(resp_tag_o), 64'(5));
        chk("single_port", 64'(resp_port_o), 64'(2));
      end
      advance();
    end
    chk("single_seen", 64'(seen), 64'(1));
    chk("single_lat", 64'(rcyc - icyc), 64'(5));
    chk("single_valid_to_resp", 64'(rcyc - vcyc), 64'(1));

    // Grant sequence from a freshly reset pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'hF; div_ready = 1'b1; resp_ready = 1'b1; lat = 1;
    for (int i = 0; i < 5; i++) begin
      drive_settle();
`ifdef FP_DIV_DISPATCH_RR_EN
      chk("rr_seq", 64'(gnt_o), 64'(4'b0001 << (i % NP)));
`else
      chk("fixed_seq", 64'(gnt_o), 64'(4'b0001));
`endif
      advance();
    end
    req = '0;
    for (int i = 0; i < 10; i++) tick();

    // Credit stall with the consumer blocked
    rand_operands();
    req = 4'hF; resp_ready = 1'b0; lat = 2; n_issue = 0;
    for (int i = 0; i < 12; i++) tick();
    chk("stall_issues", 64'(n_issue), 64'(FD));
    resp_ready = 1'b1;
    drive_settle();
    chk("pop_same_cycle_en", 64'(div_en_o), 64'(0));
    advance();
    resp_ready = 1'b0;
    drive_settle();
    chk("pop_next_cycle_en", 64'(div_en_o), 64'(1));
    advance();
    n_issue = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("post_pop_extra", 64'(n_issue), 64'(0));
    req = '0; resp_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    // Spurious return with nothing outstanding
    spur = 1'b1;
    tick();
    spur = 1'b0;
    drive_settle();
    chk("spur_err", 64'(err_o), 64'(1));
    chk("spur_empty", 64'(resp_valid_o), 64'(0));
    advance();
    for (int i = 0; i < 4; i++) tick();
    chk("spur_err_held", 64'(err_o), 64'(1));

    // Reset with two ops in flight and two queued
    resp_ready = 1'b0; req = 4'b0001; lat = 1;
    tick(); tick();
    lat = 30;
    tick(); tick();
    req = '0;
    tick();
    chk("pre_reset_queued", 64'(resp_valid_o), 64'(1));
    chk("pre_reset_inflight", 64'(dut.inflight_q), 64'(2));
    req = 4'hF; rst = 1'b1;
    drive_settle();
    chk("reset_gnt", 64'(gnt_o), 64'(0));
    advance();
    rst = 1'b0; req = '0;
    drive_settle();
    chk("post_reset_valid", 64'(resp_valid_o), 64'(0));
    chk("post_reset_inflight", 64'(dut.inflight_q), 64'(0));
    chk("post_reset_err", 64'(err_o), 64'(0));
    advance();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rand_operands();
      req        = NP'($urandom);
      div_ready  = ($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 9) < 6);
      lat        = $urandom_range(1, 6);
      tick();
    end
    req = '0; resp_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("final_err", 64'(err_o), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
